// File: rtl/battle_pkg.sv
// Shared constants for the two-Pokemon battle: HP sizing, damage rule, FSM and type codes.
package battle_pkg;

    localparam int unsigned HP_W   = 6;
    localparam int unsigned HP_MAX = 63;
    localparam int unsigned DMG    = 21;
    localparam int unsigned STAT_W = 4;
    localparam int unsigned TYPE_W = 3;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_WAIT_MOVE = 3'd1;
    localparam state_t ST_APPLY     = 3'd2;
    localparam state_t ST_ANIM      = 3'd3;
    localparam state_t ST_DONE      = 3'd4;

    localparam logic [TYPE_W-1:0] LEAF     = 3'd0;
    localparam logic [TYPE_W-1:0] FIRE     = 3'd1;
    localparam logic [TYPE_W-1:0] WATER    = 3'd2;
    localparam logic [TYPE_W-1:0] THUNDER  = 3'd3;
    localparam logic [TYPE_W-1:0] FLYING   = 3'd4;
    localparam logic [TYPE_W-1:0] ROCK     = 3'd5;
    localparam logic [TYPE_W-1:0] PSYCHIC  = 3'd6;
    localparam logic [TYPE_W-1:0] FIGHTING = 3'd7;

endpackage

// File: rtl/battle_turn_ctrl_if.sv
// Move-select side of the turn controller: start pulse, move handshake and both stat sets.
interface battle_turn_ctrl_if;
    import battle_pkg::*;

    logic                start;
    logic                move_valid;
    logic                move_ready;
    logic [STAT_W-1:0]   p1_atk;
    logic [STAT_W-1:0]   p1_def;
    logic [STAT_W-1:0]   p2_atk;
    logic [STAT_W-1:0]   p2_def;
    logic [TYPE_W-1:0]   p1_type;
    logic [TYPE_W-1:0]   p2_type;

    modport master (
        output start, move_valid, p1_atk, p1_def, p2_atk, p2_def, p1_type, p2_type,
        input  move_ready
    );

    modport slave (
        input  start, move_valid, p1_atk, p1_def, p2_atk, p2_def, p1_type, p2_type,
        output move_ready
    );

endinterface

// File: rtl/hp_damage_apply.sv
// Saturating damage step for one hit; stats and types are plumbed in for future type scaling.
module hp_damage_apply
    import battle_pkg::*;
#(
    parameter int unsigned HP_BITS = HP_W,
    parameter int unsigned DAMAGE  = DMG
) (
    input  logic [HP_BITS-1:0] hp,
    input  logic [STAT_W-1:0]  atk,
    input  logic [STAT_W-1:0]  def,
    input  logic [TYPE_W-1:0]  atk_type,
    input  logic [TYPE_W-1:0]  def_type,
    output logic [HP_BITS-1:0] hp_next,
    output logic               faint
);

    // Held for the type-effectiveness revision; the fixed rule ignores them.
    logic unused_stats;
    assign unused_stats = ^{atk, def, atk_type, def_type};

    assign faint   = (hp <= HP_BITS'(DAMAGE));
    assign hp_next = faint ? '0 : hp - HP_BITS'(DAMAGE);

endmodule

// File: rtl/battle_turn_ctrl.sv
// Turn sequencer: owns both HP registers, takes one move per turn, animates, reports the winner.
module battle_turn_ctrl
    import battle_pkg::*;
#(
    parameter int unsigned ANIM_CYCLES = 16
) (
    input  logic              clk,
    input  logic              Reset,
    battle_turn_ctrl_if.slave mv,
    output logic [HP_W-1:0]   hp1,
    output logic [HP_W-1:0]   hp2,
    output logic              active_player,
    output logic              anim_active,
    output logic              busy,
    output logic              winner_valid,
    output logic              winner,
    output logic [7:0]        turn_count
);

    localparam int unsigned CNT_W = (ANIM_CYCLES > 1) ? $clog2(ANIM_CYCLES) : 1;

    state_t              state_q, state_d;
    logic [HP_W-1:0]     hp1_q, hp1_d, hp2_q, hp2_d;
    logic                active_q, active_d;
    logic                anim_q, anim_d;
    logic                busy_q, busy_d;
    logic                wv_q, wv_d;
    logic                winner_q, winner_d;
    logic                faint_q, faint_d;
    logic [7:0]          turn_q, turn_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [STAT_W-1:0]   atk_q, atk_d, def_q, def_d;
    logic [TYPE_W-1:0]   atk_type_q, atk_type_d, def_type_q, def_type_d;

    logic [HP_W-1:0]     dmg_hp_next;
    logic                dmg_faint;

    hp_damage_apply #(
        .HP_BITS (HP_W),
        .DAMAGE  (DMG)
    ) u_damage (
        .hp       (active_q ? hp1_q : hp2_q),
        .atk      (atk_q),
        .def      (def_q),
        .atk_type (atk_type_q),
        .def_type (def_type_q),
        .hp_next  (dmg_hp_next),
        .faint    (dmg_faint)
    );

    always_comb begin
        state_d    = state_q;
        hp1_d      = hp1_q;
        hp2_d      = hp2_q;
        active_d   = active_q;
        anim_d     = anim_q;
        wv_d       = wv_q;
        winner_d   = winner_q;
        faint_d    = faint_q;
        turn_d     = turn_q;
        cnt_d      = cnt_q;
        atk_d      = atk_q;
        def_d      = def_q;
        atk_type_d = atk_type_q;
        def_type_d = def_type_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (mv.start) begin
                    hp1_d    = HP_W'(HP_MAX);
                    hp2_d    = HP_W'(HP_MAX);
                    active_d = 1'b0;
                    turn_d   = '0;
                    wv_d     = 1'b0;
                    winner_d = 1'b0;
                    state_d  = ST_WAIT_MOVE;
                end
            end
            ST_WAIT_MOVE: begin
                if (mv.move_valid) begin
                    atk_d      = active_q ? mv.p2_atk  : mv.p1_atk;
                    def_d      = active_q ? mv.p1_def  : mv.p2_def;
                    atk_type_d = active_q ? mv.p2_type : mv.p1_type;
                    def_type_d = active_q ? mv.p1_type : mv.p2_type;
                    state_d    = ST_APPLY;
                end
            end
            ST_APPLY: begin
                if (active_q) hp1_d = dmg_hp_next;
                else          hp2_d = dmg_hp_next;
                faint_d = dmg_faint;
                cnt_d   = CNT_W'(ANIM_CYCLES - 1);
                anim_d  = 1'b1;
                state_d = ST_ANIM;
            end
            ST_ANIM: begin
                if (cnt_q == '0) begin
                    anim_d = 1'b0;
                    if (faint_q) begin
                        winner_d = active_q;
                        wv_d     = 1'b1;
                        state_d  = ST_DONE;
                    end else begin
                        active_d = ~active_q;
                        if (turn_q != 8'hFF) turn_d = turn_q + 8'd1;
                        state_d  = ST_WAIT_MOVE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            hp1_q      <= '0;
            hp2_q      <= '0;
            active_q   <= 1'b0;
            anim_q     <= 1'b0;
            busy_q     <= 1'b0;
            wv_q       <= 1'b0;
            winner_q   <= 1'b0;
            faint_q    <= 1'b0;
            turn_q     <= '0;
            cnt_q      <= '0;
            atk_q      <= '0;
            def_q      <= '0;
            atk_type_q <= '0;
            def_type_q <= '0;
        end else begin
            state_q    <= state_d;
            hp1_q      <= hp1_d;
            hp2_q      <= hp2_d;
            active_q   <= active_d;
            anim_q     <= anim_d;
            busy_q     <= busy_d;
            wv_q       <= wv_d;
            winner_q   <= winner_d;
            faint_q    <= faint_d;
            turn_q     <= turn_d;
            cnt_q      <= cnt_d;
            atk_q      <= atk_d;
            def_q      <= def_d;
            atk_type_q <= atk_type_d;
            def_type_q <= def_type_d;
        end
    end

    assign mv.move_ready  = (state_q == ST_WAIT_MOVE);
    assign hp1            = hp1_q;
    assign hp2            = hp2_q;
    assign active_player  = active_q;
    assign anim_active    = anim_q;
    assign busy           = busy_q;
    assign winner_valid   = wv_q;
    assign winner         = winner_q;
    assign turn_count     = turn_q;

endmodule
